// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared states and stream framing constants for the boot loader
package imem_boot_loader_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CSUM, FLUSH, DONE, ERROR} state_t;
  localparam int LEN_BYTES = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// boot_word_assembler: shifts big-endian stream bytes into 32-bit words and strobes on each completed word
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0]  cnt;
  logic [23:0] sr;
  assign word = {sr, byte_in};
  assign word_done = en && cnt == 2'(WORD_BYTES - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      sr <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      sr <= {sr[15:0], byte_in};
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads LEN/DATA[/CSUM] byte stream into instruction memory, then releases the core (BOOT_CHECKSUM_EN enables the XOR checksum byte)
module imem_boot_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_run,
  output logic        boot_err,
  output logic [15:0] words_loaded
);
  import imem_boot_loader_pkg::*;
  state_t state, state_n;
  logic [15:0] len, len_n, word_index;
  logic [31:0] word;
  logic acc, word_done, last_word, too_long;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t FIN0 = CSUM;
  localparam state_t FINW = CSUM;
  logic [7:0] csum;
  always_ff @(posedge clk)
    csum <= !rst_n ? 8'd0 : (acc && state == DATA) ? csum ^ rx_data : csum;
`else
  localparam state_t FIN0 = DONE;
  localparam state_t FINW = FLUSH;
`endif
  assign rx_ready = rst_n && (state == LEN_HI || state == LEN_LO || state == DATA || state == CSUM);
  assign acc = rx_valid && rx_ready;
  assign len_n = {len[15:8], rx_data};
  assign too_long = 32'(len_n) > (32'd1 << ADDR_W);
  assign last_word = (word_index + 16'd1) == len;
  assign cpu_run = state == DONE;
  assign boot_err = state == ERROR;
  assign words_loaded = word_index;
  boot_word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (acc && state == DATA),
    .byte_in   (rx_data),
    .word      (word),
    .word_done (word_done)
  );
  always_comb begin
    state_n = state;
    if (state == FLUSH) state_n = DONE;
    else if (acc)
      case (state)
        LEN_HI: state_n = LEN_LO;
        LEN_LO: state_n = too_long ? ERROR : (len_n == 16'd0) ? FIN0 : DATA;
        DATA: state_n = (word_done && last_word) ? FINW : DATA;
`ifdef BOOT_CHECKSUM_EN
        CSUM: state_n = (rx_data == csum) ? DONE : ERROR;
`endif
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= LEN_HI;
      len <= '0;
      word_index <= '0;
      im_we <= 1'b0;
      im_addr <= BASE_ADDR;
      im_wdata <= '0;
    end else begin
      state <= state_n;
      im_we <= word_done;
      if (acc && state == LEN_HI) len[15:8] <= rx_data;
      if (acc && state == LEN_LO) len[7:0] <= rx_data;
      if (word_done) begin
        im_addr <= BASE_ADDR + 32'({word_index, 2'b00});
        im_wdata <= word;
        word_index <= word_index + 16'd1;
      end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and random byte streams checked against a stream-level reference model
module tb_imem_boot_loader;
  localparam logic [31:0] BASE = 32'h0;
  logic clk = 0, rst_n = 0, rx_valid = 0, take;
  logic [7:0] rx_data = 0;
  logic rx_ready, im_we, cpu_run, boot_err;
  logic [31:0] im_addr, im_wdata;
  logic [15:0] words_loaded;
  int tests = 0, fails = 0, cyc = 0, run_cyc = -1, err_cyc = -1, rdy_drop = 0;
  logic [7:0] stim[$];
  int acc_t[$], w_cyc[$];
  logic [31:0] w_addr[$], w_data[$];

  imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_run(cpu_run),
    .boot_err(boot_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      w_addr.push_back(im_addr);
      w_data.push_back(im_wdata);
      w_cyc.push_back(cyc);
    end
    if (cpu_run === 1'b1 && run_cyc < 0) run_cyc = cyc;
    if (boot_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    run_cyc = -1; err_cyc = -1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 0; rx_valid = 0;
    #1 chk("rst_rx_ready", 32'(rx_ready), 0);
    @(negedge clk);
    chk("rst_im_we", 32'(im_we), 0);
    chk("rst_im_addr", im_addr, BASE);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_boot_err", 32'(boot_err), 0);
    chk("rst_words", 32'(words_loaded), 0);
    rst_n = 1;
    #1 chk("rst_rx_ready_after", 32'(rx_ready), 1);
  endtask

  // mode 0: valid every cycle, 1: valid one cycle in three, 2: random valid
  task automatic send(input int cnt, input int mode);
    int i = 0, waitc = 0, ph = 0;
    acc_t.delete(); rdy_drop = 0;
    while (i < cnt) begin
      @(negedge clk);
      rx_valid = mode == 0 ? 1'b1 : mode == 1 ? (ph % 3 == 0) : 1'($urandom_range(1, 0));
      ph++;
      rx_data = rx_valid ? stim[i] : 8'($urandom);
      #1;
      if (!rx_ready) rdy_drop++;
      take = rx_valid && rx_ready;
      @(posedge clk);
      #1;
      if (take) begin
        acc_t.push_back(cyc);
        i++;
        waitc = 0;
      end else if (++waitc > 100) begin
        tests++; fails++;
        $display("FAIL send: byte %0d never accepted", i);
        break;
      end
    end
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic check_stream(input string tag);
    int n, nw, exp_run, exp_err, last;
    logic [7:0] x;
    logic [31:0] w;
    repeat (4) @(negedge clk);
    n = int'({stim[0], stim[1]});
    nw = n > 256 ? 0 : n;
    x = 0; exp_run = -1; exp_err = -1;
    for (int k = 0; k < nw; k++) x ^= stim[2+4*k] ^ stim[3+4*k] ^ stim[4+4*k] ^ stim[5+4*k];
    chk({tag, "_rx_ready_held"}, 32'(rdy_drop), 0);
    chk({tag, "_nwrites"}, 32'(w_addr.size()), 32'(nw));
    for (int k = 0; k < nw && k < w_addr.size(); k++) begin
      w = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
      chk($sformatf("%s_addr%0d", tag, k), w_addr[k], BASE + 32'(4 * k));
      chk($sformatf("%s_data%0d", tag, k), w_data[k], w);
      chk($sformatf("%s_wcyc%0d", tag, k), 32'(w_cyc[k]), 32'(acc_t[5+4*k]));
    end
    if (n > 256) exp_err = acc_t[1];
    else begin
`ifdef BOOT_CHECKSUM_EN
      last = 2 + 4 * n;
      if (stim[last] == x) exp_run = acc_t[last];
      else exp_err = acc_t[last];
`else
      last = 1 + 4 * n;
      exp_run = n == 0 ? acc_t[last] : acc_t[last] + 1;
`endif
    end
    chk({tag, "_run_cyc"}, 32'(run_cyc), 32'(exp_run));
    chk({tag, "_err_cyc"}, 32'(err_cyc), 32'(exp_err));
    chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(exp_run >= 0));
    chk({tag, "_boot_err"}, 32'(boot_err), 32'(exp_err >= 0));
    chk({tag, "_words"}, 32'(words_loaded), 32'(nw));
    chk({tag, "_rx_ready_end"}, 32'(rx_ready), 0);
  endtask

  task automatic build_random(input int n, input bit good);
    logic [7:0] x = 0, b;
    stim = '{8'(n >> 8), 8'(n)};
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      stim.push_back(b);
      x ^= b;
    end
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(good ? x : x ^ 8'(1 + $urandom_range(254, 0)));
`else
    if (!good) x = 0;
`endif
  endtask

  task automatic run(input string tag, input int mode);
    reset_dut();
    clear_mon();
    send(stim.size(), mode);
    check_stream(tag);
  endtask

  initial begin
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(8'h89);
`endif
    run("normal", 0);
`ifdef BOOT_CHECKSUM_EN
    stim[10] = 8'h00;
    run("badcsum", 0);
`endif
    stim = '{8'h01, 8'h01};
    run("overflow", 0);
    stim = '{8'hFF, 8'hFF};
    run("overflow_max", 2);
    stim = '{8'h00, 8'h01, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(8'h81);
`endif
    run("throttled", 1);
    reset_dut();
    clear_mon();
    send(4, 0);
    reset_dut();
    repeat (3) @(negedge clk);
    chk("midreset_nwrites", 32'(w_addr.size()), 0);
    chk("midreset_words", 32'(words_loaded), 0);
    chk("midreset_cpu_run", 32'(cpu_run), 0);
    send(stim.size(), 0);
    check_stream("after_midreset");
    stim = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run("len0", 0);
    build_random(256, 1);
    run("full_depth", 0);
    for (int r = 0; r < 8; r++) begin
      build_random($urandom_range(6, 0), r % 3 != 2);
      run($sformatf("rand%0d", r), $urandom_range(2, 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
